// File: rtl/aes_enc_round_engine.sv
// aes_enc_round_engine: iterative AES encryption core, one round per clock.
//   IDLE  : waits for a plaintext; on accept loads in_data ^ round key 0.
//   ROUND : round counter r runs 1..NR; rounds 1..NR-1 do SubBytes,
//           ShiftRows, MixColumns, AddRoundKey(r); round NR skips MixColumns.
//   DONE  : ciphertext held in the state register until out_ready.
// The expanded key schedule is supplied externally and read live every round.
// Optional build macro AES_KEY_GATE_EN: when defined, in_ready also requires
// keys_valid; when undefined, keys_valid is ignored.
// State byte i sits at bits [127-8*i -: 8]; byte i is row i%4, column i/4.

// 32-bit S-box lane: four independent byte substitutions.
module subBytes (
   input  logic [31:0] data,
   output logic [31:0] result
);

   // GF(2^8) product, reduction polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (0 maps to 0), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x3, x7, x15, x31, x63, x127, inv;
      x3   = gf_mul(gf_mul(x, x), x);
      x7   = gf_mul(gf_mul(x3, x3), x);
      x15  = gf_mul(gf_mul(x7, x7), x);
      x31  = gf_mul(gf_mul(x15, x15), x);
      x63  = gf_mul(gf_mul(x31, x31), x);
      x127 = gf_mul(gf_mul(x63, x63), x);
      inv  = gf_mul(x127, x127);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Substitute each byte of the word.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch or
      // loop, so no path can leave it unassigned and infer a latch.
      result = '0;
      for (int i = 0; i < 4; i++) begin
         result[8*i +: 8] = sbox(data[8*i +: 8]);
      end
   end

endmodule

module aes_enc_round_engine #(
   parameter int NK = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [128*(NK+7)-1:0]   round_keys,
   input  logic                    keys_valid,
   input  logic                    in_valid,
   input  logic [127:0]            in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [127:0]            out_data,
   input  logic                    out_ready,
   output logic                    busy
);

   localparam int         NR    = NK + 6;
   localparam int         NKEYS = NK + 7;
   localparam int         KW    = 128 * NKEYS;
   localparam logic [3:0] LAST  = 4'(NR);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   fsm_t         fsm;
   fsm_t         fsm_next;
   logic [3:0]   round;
   logic [127:0] aes_state;

   logic [127:0] rk [NKEYS];
   logic [127:0] round_key;
   logic [127:0] sub_out;
   logic [127:0] shift_out;
   logic [127:0] mix_out;
   logic [127:0] round_out;
   logic         accept;
   logic         last_round;

   // xtime: multiply by x in GF(2^8), modulus 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One MixColumns column: rows 0..3 are the MSB..LSB bytes of col.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Slice the flat schedule into round keys; key 0 occupies the MSBs.
   for (genvar i = 0; i < NKEYS; i++) begin : g_rk
      assign rk[i] = round_keys[KW-1-128*i -: 128];
   end

   // Key for the round in progress; the counter is 0 only outside ROUND.
   assign round_key = rk[round];

   // SubBytes: one 32-bit lane per state column.
   for (genvar c = 0; c < 4; c++) begin : g_sub
      subBytes u_sub (
         .data   (aes_state[127-32*c -: 32]),
         .result (sub_out[127-32*c -: 32])
      );
   end

   // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
   always_comb begin
      shift_out = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shift_out[127-8*(4*c+r) -: 8] = sub_out[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
   end

   // MixColumns on each of the four columns.
   always_comb begin
      mix_out = '0;
      for (int c = 0; c < 4; c++) begin
         mix_out[127-32*c -: 32] = mix_column(shift_out[127-32*c -: 32]);
      end
   end

   assign last_round = (round == LAST);
   assign round_out  = round_key ^ (last_round ? shift_out : mix_out);

   // Handshake-facing outputs decoded from the FSM state.
`ifdef AES_KEY_GATE_EN
   assign in_ready = (fsm == IDLE) && keys_valid;
`else
   logic keys_valid_unused;
   assign keys_valid_unused = keys_valid;
   assign in_ready = (fsm == IDLE);
`endif

   assign accept    = in_valid && in_ready;
   assign out_valid = (fsm == DONE);
   assign busy      = (fsm == ROUND) || (fsm == DONE);
   assign out_data  = aes_state;

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it is tested inside the clocked block
      // and never appears in the sensitivity list.
      if (reset) begin
         fsm <= IDLE;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         fsm <= fsm_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      fsm_next = fsm;
      case (fsm)
         IDLE:    if (accept)     fsm_next = ROUND;
         ROUND:   if (last_round) fsm_next = DONE;
         DONE:    if (out_ready)  fsm_next = IDLE;
         default:                 fsm_next = IDLE;
      endcase
   end

   // Datapath: initial key whitening on accept, one cipher round per ROUND cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the cipher state is cleared on reset because it is visible
         // on out_data; the round keys are inputs and hold no storage here.
         round     <= 4'd0;
         aes_state <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (accept) begin
                  aes_state <= in_data ^ rk[0];
                  round     <= 4'd1;
               end
            end
            ROUND: begin
               aes_state <= round_out;
               round     <= last_round ? 4'd0 : round + 4'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_enc_round_engine.sv
// Self-checking bench for aes_enc_round_engine: NK=4 instance for handshake,
// reset and backpressure scenarios; NK=6 and NK=8 instances for known answers.
// Expected ciphertexts come from a byte-array AES model with a table S-box.
module tb_aes_enc_round_engine;

   localparam int KW4 = 128 * 11;
   localparam int KW6 = 128 * 13;
   localparam int KW8 = 128 * 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic [KW4-1:0]   rk4_bus;
   logic             keys_valid, in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0]     in_data, out_data;

   logic [KW6-1:0]   rk6_bus;
   logic [KW8-1:0]   rk8_bus;
   logic             w_in_valid, w_out_ready;
   logic [127:0]     w_in_data;
   logic             in_ready6, out_valid6, busy6, in_ready8, out_valid8, busy8;
   logic [127:0]     out_data6, out_data8;

   int vectors    = 0;
   int miscompares = 0;

   aes_enc_round_engine #(.NK(4)) dut (
      .clk(clk), .reset(reset), .round_keys(rk4_bus), .keys_valid(keys_valid),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
   );

   aes_enc_round_engine #(.NK(6)) dut6 (
      .clk(clk), .reset(reset), .round_keys(rk6_bus), .keys_valid(1'b1),
      .in_valid(w_in_valid), .in_data(w_in_data), .in_ready(in_ready6),
      .out_valid(out_valid6), .out_data(out_data6), .out_ready(w_out_ready), .busy(busy6)
   );

   aes_enc_round_engine #(.NK(8)) dut8 (
      .clk(clk), .reset(reset), .round_keys(rk8_bus), .keys_valid(1'b1),
      .in_valid(w_in_valid), .in_data(w_in_data), .in_ready(in_ready8),
      .out_valid(out_valid8), .out_data(out_data8), .out_ready(w_out_ready), .busy(busy8)
   );

   // ---------------- reference model ----------------
   logic [2047:0] sbox_tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic [127:0] sched [3][15];

   function automatic logic [7:0] sbox_f(input logic [7:0] x);
      return sbox_tbl[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      int p, aa;
      p  = 0;
      aa = int'(a);
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa << 1;
         if (aa >= 256) aa = aa ^ 'h11b;
      end
      return p[7:0];
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
   endfunction

   // Key expansion into sched[idx]; also drives the matching DUT key bus.
   task automatic expand(input int idx, input int nk, input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          total;
      total = 4 * (nk + 7);
      rc    = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < total; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 15; r++)
         sched[idx][r] = (r < nk + 7) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      if (idx == 0) for (int r = 0; r < 11; r++) rk4_bus[KW4-1-128*r -: 128] = sched[0][r];
      if (idx == 1) for (int r = 0; r < 13; r++) rk6_bus[KW6-1-128*r -: 128] = sched[1][r];
      if (idx == 2) for (int r = 0; r < 15; r++) rk8_bus[KW8-1-128*r -: 128] = sched[2][r];
   endtask

   function automatic logic [127:0] model(input logic [127:0] pt, input int idx);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] k, res;
      int           nr;
      nr = (idx == 0) ? 10 : (idx == 1) ? 12 : 14;
      k  = sched[idx][0];
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_f(s[i]);
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               t[row + 4*col] = s[row + 4*((col + row) % 4)];
         for (int col = 0; col < 4; col++) begin
            if (rnd < nr) begin
               s[4*col]   = gmul(t[4*col], 2) ^ gmul(t[4*col+1], 3) ^ t[4*col+2] ^ t[4*col+3];
               s[4*col+1] = t[4*col] ^ gmul(t[4*col+1], 2) ^ gmul(t[4*col+2], 3) ^ t[4*col+3];
               s[4*col+2] = t[4*col] ^ t[4*col+1] ^ gmul(t[4*col+2], 2) ^ gmul(t[4*col+3], 3);
               s[4*col+3] = gmul(t[4*col], 3) ^ t[4*col+1] ^ t[4*col+2] ^ gmul(t[4*col+3], 2);
            end else begin
               for (int row = 0; row < 4; row++) s[4*col+row] = t[4*col+row];
            end
         end
         k = sched[idx][rnd];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- drivers (no comparisons) ----------------
   // Offer pt until accepted; returns on the negedge of the first ROUND cycle.
   task automatic accept_block(input logic [127:0] pt, output bit ok);
      int n = 0;
      in_valid = 1'b1;
      in_data  = pt;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      ok = in_ready;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = rand128();
   endtask

   // lat = index of the first out_valid cycle, the accept cycle being 0.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_out(input int hold);
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run_wide(input logic [127:0] pt, output logic [127:0] got6, output int lat6,
                           output logic [127:0] got8, output int lat8);
      int n = 0;
      got6 = '0; got8 = '0; lat6 = -1; lat8 = -1;
      w_out_ready = 1'b1;
      w_in_valid  = 1'b1;
      w_in_data   = pt;
      while (!(in_ready6 && in_ready8) && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      w_in_valid = 1'b0;
      for (int c = 1; c < 40; c++) begin
         if (out_valid6 && lat6 < 0) begin lat6 = c; got6 = out_data6; end
         if (out_valid8 && lat8 < 0) begin lat8 = c; got8 = out_data8; end
         if (lat6 > 0 && lat8 > 0) break;
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_data = rand128(); out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (out_data !== 128'h0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data); end
   endtask

   task automatic test_kat();
      logic [127:0] pt, got6, got8;
      int lat, lat6, lat8;
      bit ok;
      pt = 128'h00112233445566778899aabbccddeeff;
      expand(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
      accept_block(pt, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL kat4_accept: got no accept want accept"); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL kat4_busy: got %b want 1", busy); end
      wait_done(lat);
      vectors++; if (out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin miscompares++; $display("FAIL kat4_data: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", out_data); end
      vectors++; if (lat != 11) begin miscompares++; $display("FAIL kat4_latency: got %0d want 11", lat); end
      release_out(0);
      expand(1, 6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
      expand(2, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      run_wide(pt, got6, lat6, got8, lat8);
      vectors++; if (got6 !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191) begin miscompares++; $display("FAIL kat6_data: got %h want dda97ca4864cdfe06eaf70a0ec0d7191", got6); end
      vectors++; if (lat6 != 13) begin miscompares++; $display("FAIL kat6_latency: got %0d want 13", lat6); end
      vectors++; if (got8 !== 128'h8ea2b7ca516745bfeafc49904b496089) begin miscompares++; $display("FAIL kat8_data: got %h want 8ea2b7ca516745bfeafc49904b496089", got8); end
      vectors++; if (lat8 != 15) begin miscompares++; $display("FAIL kat8_latency: got %0d want 15", lat8); end
   endtask

   task automatic test_random();
      logic [127:0] pt, exp, got6, got8;
      int lat, lat6, lat8;
      bit ok;
      for (int k = 0; k < 6; k++) begin
         expand(0, 4, {rand128(), 128'h0});
         pt  = rand128();
         exp = model(pt, 0);
         accept_block(pt, ok);
         wait_done(lat);
         vectors++; if (out_data !== exp) begin miscompares++; $display("FAIL rand4_data[%0d]: got %h want %h", k, out_data, exp); end
         vectors++; if (lat != 11) begin miscompares++; $display("FAIL rand4_latency[%0d]: got %0d want 11", k, lat); end
         release_out($urandom_range(0, 3));
      end
      for (int k = 0; k < 2; k++) begin
         expand(1, 6, {rand128(), $urandom, $urandom, 64'h0});
         expand(2, 8, {rand128(), rand128()});
         pt = rand128();
         run_wide(pt, got6, lat6, got8, lat8);
         vectors++; if (got6 !== model(pt, 1)) begin miscompares++; $display("FAIL rand6_data[%0d]: got %h want %h", k, got6, model(pt, 1)); end
         vectors++; if (got8 !== model(pt, 2)) begin miscompares++; $display("FAIL rand8_data[%0d]: got %h want %h", k, got8, model(pt, 2)); end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] pt, exp;
      int lat;
      bit ok;
      expand(0, 4, {rand128(), 128'h0});
      pt  = rand128();
      exp = model(pt, 0);
      accept_block(pt, ok);
      in_valid = 1'b1;              // offered while busy: must be ignored
      in_data  = rand128();
      wait_done(lat);
      vectors++; if (lat != 11) begin miscompares++; $display("FAIL bp_latency: got %0d want 11", lat); end
      for (int c = 0; c < 5; c++) begin
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, out_valid); end
         vectors++; if (out_data !== exp) begin miscompares++; $display("FAIL bp_out_data[%0d]: got %h want %h", c, out_data, exp); end
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_still_valid: got %b want 1", out_valid); end
      @(negedge clk);
      out_ready = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_release_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] pt, exp;
      int lat;
      bit ok, saw;
      expand(0, 4, {rand128(), 128'h0});
      pt  = rand128();
      exp = model(pt, 0);
      accept_block(pt, ok);
      repeat (4) @(negedge clk);    // round counter now 5
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
      vectors++; if (out_data !== 128'h0) begin miscompares++; $display("FAIL rmid_out_data: got %h want 0", out_data); end
      saw = 1'b0;
      repeat (20) begin
         if (out_valid) saw = 1'b1;
         @(negedge clk);
      end
      vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL rmid_no_out_valid: got %b want 0", saw); end
      accept_block(pt, ok);
      wait_done(lat);
      vectors++; if (out_data !== exp) begin miscompares++; $display("FAIL rmid_reissue_data: got %h want %h", out_data, exp); end
      vectors++; if (lat != 11) begin miscompares++; $display("FAIL rmid_reissue_latency: got %0d want 11", lat); end
      // reset in DONE coinciding with out_ready and in_valid: reset wins
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = rand128();
      reset     = 1'b1;
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      vectors++; if (out_data !== 128'h0) begin miscompares++; $display("FAIL rdone_out_data: got %h want 0", out_data); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rdone_busy: got %b want 0", busy); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rdone_out_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] pts [2];
      logic [127:0] outs [$];
      int           acc_cyc [$];
      expand(0, 4, {rand128(), 128'h0});
      pts[0]    = rand128();
      pts[1]    = rand128();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = pts[0];
      for (int cyc = 0; cyc < 80 && outs.size() < 2; cyc++) begin
         if (out_valid) outs.push_back(out_data);
         if (in_valid && in_ready) acc_cyc.push_back(cyc);
         @(negedge clk);
         if (acc_cyc.size() == 1) in_data = pts[1];
         if (acc_cyc.size() == 2) in_valid = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      while (outs.size() < 2) outs.push_back('0);
      while (acc_cyc.size() < 2) acc_cyc.push_back(-100);
      vectors++; if (outs[0] !== model(pts[0], 0)) begin miscompares++; $display("FAIL b2b_first: got %h want %h", outs[0], model(pts[0], 0)); end
      vectors++; if (outs[1] !== model(pts[1], 0)) begin miscompares++; $display("FAIL b2b_second: got %h want %h", outs[1], model(pts[1], 0)); end
      vectors++; if (acc_cyc[1] - acc_cyc[0] != 12) begin miscompares++; $display("FAIL b2b_interval: got %0d want 12", acc_cyc[1] - acc_cyc[0]); end
   endtask

   task automatic test_key_gate();
      logic [127:0] pt, exp;
      int lat;
      bit ok;
      expand(0, 4, {rand128(), 128'h0});
      pt  = rand128();
      exp = model(pt, 0);
`ifdef AES_KEY_GATE_EN
      keys_valid = 1'b0;
      in_valid   = 1'b1;
      in_data    = pt;
      for (int c = 0; c < 10; c++) begin
         #1;
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL gate_in_ready[%0d]: got %b want 0", c, in_ready); end
         vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL gate_no_accept[%0d]: got %b want 0", c, busy); end
         @(negedge clk);
      end
      keys_valid = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL gate_open: got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gate_accept: got %b want 1", busy); end
      wait_done(lat);
`else
      keys_valid = 1'b0;
      in_valid   = 1'b1;
      in_data    = pt;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL nogate_in_ready: got %b want 1", in_ready); end
      accept_block(pt, ok);
      wait_done(lat);
      keys_valid = 1'b1;
`endif
      vectors++; if (out_data !== exp) begin miscompares++; $display("FAIL gate_data: got %h want %h", out_data, exp); end
      vectors++; if (lat != 11) begin miscompares++; $display("FAIL gate_latency: got %0d want 11", lat); end
      release_out(0);
   endtask

   initial begin
      reset = 1'b1; keys_valid = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b1;
      rk4_bus = '0; rk6_bus = '0; rk8_bus = '0;
      @(negedge clk);
      test_reset();
      test_kat();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_key_gate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/aes_enc_round_engine.md
AES_ENC_ROUND_ENGINE -- requirements
Module: aes_enc_round_engine

Interface
REQ-001 The block SHALL have parameter NK, default 4, meaning key length in 32-bit words (legal values 4, 6, 8); round count NR = NK+6.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port round_keys, input, 128*(NK+7) bits: expanded schedule; round key r = bits [128*(NK+7)-1-128*r -: 128]; key word 0 is in the MSBs.
REQ-005 The block SHALL have port keys_valid, input, 1 bit: round_keys is complete and stable.
REQ-006 The block SHALL have port in_valid, input, 1 bit: plaintext offered.
REQ-007 The block SHALL have port in_data, input, 128 bits: plaintext; byte 0 is in bits [127:120], column-major state order.
REQ-008 The block SHALL have port in_ready, output, 1 bit: engine can accept a block.
REQ-009 The block SHALL have port out_valid, output, 1 bit: ciphertext available.
REQ-010 The block SHALL have port out_data, output, 128 bits: ciphertext, same byte order as in_data.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-012 The block SHALL have port busy, output, 1 bit: high in states ROUND and DONE.

Function
REQ-013 The FSM SHALL have the states IDLE, ROUND and DONE.
REQ-014 Accept: on a clk edge with in_valid and in_ready both high, state SHALL load in_data XOR round key 0, the round counter SHALL be set to 1, and the FSM SHALL go IDLE->ROUND.
REQ-015 In ROUND with counter r < NR, each cycle SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey(r), then increment r.
REQ-016 In ROUND with r == NR, the cycle SHALL apply SubBytes, ShiftRows and AddRoundKey(NR) with no MixColumns, and the FSM SHALL go ROUND->DONE.
REQ-017 Latency SHALL be exactly NR+1 cycles from the accept edge to the first cycle with out_valid high (NR=10/12/14).
REQ-018 out_valid SHALL be high only in DONE, and out_data SHALL equal the state register, held stable while out_valid is high and out_ready is low.
REQ-019 On a clk edge with out_valid and out_ready both high, the FSM SHALL go DONE->IDLE; no new block is accepted on that same edge, so the back-to-back issue interval is NR+2 cycles minimum.
REQ-020 in_ready SHALL be high only in IDLE, gated as specified in REQ-027/REQ-028.
REQ-021 round_keys SHALL be sampled live each round; a change to round_keys mid-operation corrupts only the current block and SHALL NOT be detected.
REQ-022 SubBytes SHALL be built from four instances of the existing 32-bit subBytes module; MixColumns SHALL use GF(2^8) xtime with modulus 0x11B.
REQ-023 in_valid high while in_ready is low SHALL be ignored and SHALL have no state effect.

Reset
REQ-024 When reset is high at a clk edge, the block SHALL force state IDLE, round counter 0, state register 0, out_valid 0, busy 0 and out_data 0.
REQ-025 A reset asserted mid-operation (ROUND or DONE) SHALL abort the block with no out_valid pulse, and in_ready SHALL be high on the first cycle after reset deasserts (subject to REQ-027).
REQ-026 Reset SHALL have priority over every simultaneous handshake event.

Configuration
REQ-027 With macro AES_KEY_GATE_EN defined, in_ready SHALL equal (state==IDLE) AND keys_valid.
REQ-028 With AES_KEY_GATE_EN undefined, in_ready SHALL equal (state==IDLE), and keys_valid SHALL be ignored.

Verification
REQ-029 NK=4, key 000102030405060708090a0b0c0d0e0f expanded, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid on cycle 11 after accept.
REQ-030 NK=6, key 000102...1617, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 at cycle 13; NK=8, key 000102...1e1f -> 8ea2b7ca516745bfeafc49904b496089 at cycle 15.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready stays 0; release -> IDLE on the next edge.
REQ-032 Reset asserted at round 5 -> no out_valid; in_ready=1 the cycle after reset deasserts; a re-issued block gives the correct ciphertext.
REQ-033 AES_KEY_GATE_EN defined, keys_valid=0, in_valid=1 for 10 cycles -> in_ready=0 and no accept; raise keys_valid -> accept on the next edge.
REQ-034 Two back-to-back blocks with out_ready tied to 1 -> both ciphertexts correct, with accepts 12 cycles apart for NK=4.
